// File: rtl/multdiv_sequencer_if.sv
// Signal bundle between the execute stage, multdiv_sequencer and the multdiv unit.
// slave = the sequencer; master = its environment (requesting pipeline plus multdiv unit).
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [TAG_W-1:0] dest_tag;
  logic             flush;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic             result_exception;
  logic [TAG_W-1:0] result_tag;
  logic             md_ctrl_mult;
  logic             md_ctrl_div;
  logic [WIDTH-1:0] md_operand_a;
  logic [WIDTH-1:0] md_operand_b;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;
  logic             md_resultRDY;

  modport master (
    output start_mult, start_div, operand_a, operand_b, dest_tag, flush,
    output md_result, md_exception, md_resultRDY,
    input  stall, result_valid, result, result_exception, result_tag,
    input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b
  );

  modport slave (
    input  start_mult, start_div, operand_a, operand_b, dest_tag, flush,
    input  md_result, md_exception, md_resultRDY,
    output stall, result_valid, result, result_exception, result_tag,
    output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Runs one multi-cycle multiply/divide for the execute stage: issue pulse, wait with
// timeout, return result/exception/tag, hold the pipeline and absorb flushes.
//
// state | meaning
// IDLE  | no op in flight, accepting start_mult/start_div
// ISSUE | ctrl pulse to multdiv this cycle, counter cleared
// WAIT  | counting until md_resultRDY or timeout
// DONE  | result_valid pulse, pipeline released
// DRAIN | flushed op still running in multdiv; its result is discarded
module multdiv_sequencer #(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 5,
  parameter int MAX_CYCLES = 40
) (
  input logic                clock,
  input logic                reset,
  multdiv_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_w;
  logic             start_w;
  logic             ctrl_mult_q;
  logic             ctrl_div_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic             exc_q;
  logic [TAG_W-1:0] rtag_q;

  assign start_w = bus.start_mult | bus.start_div;

  always_comb begin
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_w = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      res_q       <= '0;
      exc_q       <= 1'b0;
      rtag_q      <= '0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      valid_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_w && !bus.flush) begin
            opa_q       <= bus.operand_a;
            opb_q       <= bus.operand_b;
            tag_q       <= bus.dest_tag;
            // multiply wins when both are requested together
            ctrl_mult_q <= bus.start_mult;
            ctrl_div_q  <= !bus.start_mult;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= bus.flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (bus.md_resultRDY || timeout_w) begin
            if (bus.flush) begin
              state_q <= S_IDLE;
            end else begin
              res_q   <= bus.md_resultRDY ? bus.md_result : '0;
              exc_q   <= bus.md_resultRDY ? bus.md_exception : 1'b1;
              rtag_q  <= tag_q;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (bus.flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DONE: state_q <= S_IDLE;
        S_DRAIN: begin
          cnt_q <= cnt_d;
          if (bus.md_resultRDY || timeout_w) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // combinational so the requester freezes in the same cycle it asks
  assign bus.stall = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                     ((state_q == S_IDLE) && start_w && !bus.flush) ||
                     ((state_q == S_DRAIN) && start_w);

  assign bus.md_ctrl_mult     = ctrl_mult_q;
  assign bus.md_ctrl_div      = ctrl_div_q;
  assign bus.md_operand_a     = opa_q;
  assign bus.md_operand_b     = opb_q;
  assign bus.result_valid     = valid_q;
  assign bus.result           = res_q;
  assign bus.result_exception = exc_q;
  assign bus.result_tag       = rtag_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: a per-cycle expected timeline built from request
// time and multdiv latency, checked every cycle, plus literal pins on key results.
module tb_multdiv_sequencer;
  localparam int W     = 32;
  localparam int TW    = 5;
  localparam int MAXC  = 40;
  localparam int DEPTH = 1024;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multdiv_sequencer_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  multdiv_sequencer #(.WIDTH(W), .TAG_W(TW), .MAX_CYCLES(MAXC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // multdiv unit model: answers rsp_lat cycles after the ctrl pulse (0 = never)
  logic         rsp_rdy;
  logic         rsp_exc;
  logic [W-1:0] rsp_res;
  int           rsp_lat;
  int           rsp_cnt;
  bit           rsp_armed;
  assign bus.md_resultRDY = rsp_rdy;
  assign bus.md_result    = rsp_res;
  assign bus.md_exception = rsp_exc;

  initial begin
    rsp_rdy = 1'b0; rsp_exc = 1'b0; rsp_res = '0; rsp_cnt = 0; rsp_armed = 1'b0;
    forever begin
      @(posedge clock); #1;
      rsp_rdy = 1'b0;
      if (rsp_armed) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin rsp_rdy = 1'b1; rsp_armed = 1'b0; end
      end
      if ((bus.md_ctrl_mult || bus.md_ctrl_div) && rsp_lat != 0) begin
        rsp_armed = 1'b1;
        rsp_cnt   = rsp_lat;
        if (bus.md_ctrl_mult) begin
          rsp_res = bus.md_operand_a * bus.md_operand_b; rsp_exc = 1'b0;
        end else if (bus.md_operand_b == '0) begin
          rsp_res = '0; rsp_exc = 1'b1;
        end else begin
          rsp_res = bus.md_operand_a / bus.md_operand_b; rsp_exc = 1'b0;
        end
      end
    end
  end

  // expected timeline, indexed by cycle number
  bit            e_stall [DEPTH];
  bit            e_cm    [DEPTH];
  bit            e_cd    [DEPTH];
  bit            e_valid [DEPTH];
  bit            e_exc   [DEPTH];
  logic [W-1:0]  e_opa   [DEPTH];
  logic [W-1:0]  e_opb   [DEPTH];
  logic [W-1:0]  e_res   [DEPTH];
  logic [TW-1:0] e_tag   [DEPTH];
  logic [W-1:0]  h_res;
  logic          h_exc;
  logic [TW-1:0] h_tag;
  int cyc, n_pass, n_total, last_valid;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic check_cycle();
    if (cyc >= DEPTH) begin
      chk("cycle_budget", W'(cyc), W'(DEPTH - 1));
      return;
    end
    if (!reset) begin
      h_res = '0; h_exc = 1'b0; h_tag = '0;
    end else if (e_valid[cyc]) begin
      h_res = e_res[cyc]; h_exc = e_exc[cyc]; h_tag = e_tag[cyc];
    end
    if (bus.result_valid) last_valid = cyc;
    chk("stall",        W'(bus.stall),        W'(e_stall[cyc]));
    chk("md_ctrl_mult", W'(bus.md_ctrl_mult), W'(e_cm[cyc]));
    chk("md_ctrl_div",  W'(bus.md_ctrl_div),  W'(e_cd[cyc]));
    if (e_cm[cyc] || e_cd[cyc]) begin
      chk("md_operand_a", bus.md_operand_a, e_opa[cyc]);
      chk("md_operand_b", bus.md_operand_b, e_opb[cyc]);
    end
    chk("result_valid",     W'(bus.result_valid),     W'(e_valid[cyc]));
    chk("result",           bus.result,               h_res);
    chk("result_exception", W'(bus.result_exception), W'(h_exc));
    chk("result_tag",       W'(bus.result_tag),       W'(h_tag));
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // request seen in cycle r; multdiv answers e cycles after the ctrl pulse (or times out)
  task automatic plan_op(int r, int e, bit tmo, bit isdiv,
                         logic [W-1:0] a, logic [W-1:0] b, logic [TW-1:0] tag);
    for (int i = r; i <= r + 1 + e; i++) e_stall[i] = 1'b1;
    if (isdiv) e_cd[r+1] = 1'b1; else e_cm[r+1] = 1'b1;
    e_opa[r+1]     = a;
    e_opb[r+1]     = b;
    e_valid[r+2+e] = 1'b1;
    e_tag[r+2+e]   = tag;
    e_exc[r+2+e]   = tmo || (isdiv && b == '0);
    e_res[r+2+e]   = tmo ? '0 : (isdiv ? ((b == '0) ? '0 : a / b) : a * b);
  endtask

  task automatic clear_from(int c);
    for (int i = c; i < DEPTH; i++) begin
      e_stall[i] = 1'b0; e_cm[i] = 1'b0; e_cd[i] = 1'b0; e_valid[i] = 1'b0;
    end
  endtask

  task automatic run_op(bit sm, bit sd, logic [W-1:0] a, logic [W-1:0] b,
                        logic [TW-1:0] tag, int lat, output int r);
    bit tmo;
    int e;
    tmo = (lat == 0) || (lat > MAXC);
    e   = tmo ? MAXC : lat;
    r   = cyc;
    rsp_lat = lat;
    plan_op(r, e, tmo, !sm, a, b, tag);
    bus.start_mult = sm; bus.start_div = sd;
    bus.operand_a = a; bus.operand_b = b; bus.dest_tag = tag;
    repeat (e + 3) step();
    bus.start_mult = 1'b0; bus.start_div = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, r2;
    cyc = 0; n_pass = 0; n_total = 0; last_valid = -1; rsp_lat = 0;
    h_res = '0; h_exc = 1'b0; h_tag = '0;
    reset = 1'b0;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.flush = 1'b0;
    bus.operand_a = '0; bus.operand_b = '0; bus.dest_tag = '0;
    step(); step();
    chk("rst_result_valid", W'(bus.result_valid), '0);
    chk("rst_md_operand_a", bus.md_operand_a, '0);
    reset = 1'b1;
    step(); step();

    // mult 6*7, ready 32 cycles after the pulse
    run_op(1'b1, 1'b0, 6, 7, 3, 32, r);
    chk("mult_valid_delay", W'(last_valid - r), 34);
    chk("mult_result_lit",  bus.result, 42);
    chk("mult_tag_lit",     W'(bus.result_tag), 3);
    chk("mult_exc_lit",     W'(bus.result_exception), 0);
    step(); step();

    // divide by zero reported by multdiv
    run_op(1'b0, 1'b1, 100, 0, 9, 10, r);
    chk("div0_exc_lit", W'(bus.result_exception), 1);
    step();

    // multdiv never answers: timeout
    run_op(1'b1, 1'b0, 3, 3, 5, 0, r);
    chk("timeout_delay",  W'(last_valid - r), 42);
    chk("timeout_result", bus.result, 0);
    chk("timeout_exc",    W'(bus.result_exception), 1);
    step();

    // start together with flush in IDLE is ignored
    bus.start_mult = 1'b1; bus.flush = 1'b1; bus.operand_a = 8; bus.operand_b = 8;
    step();
    bus.start_mult = 1'b0; bus.flush = 1'b0;
    step(); step();

    // flush 5 cycles into WAIT, divide requested during DRAIN
    r = cyc; rsp_lat = 12;
    for (int i = r; i <= r + 7; i++) e_stall[i] = 1'b1;
    e_cm[r+1] = 1'b1; e_opa[r+1] = 11; e_opb[r+1] = 13;
    bus.start_mult = 1'b1; bus.operand_a = 11; bus.operand_b = 13; bus.dest_tag = 4;
    repeat (7) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.start_mult = 1'b0;
    step(); step();
    for (int i = r + 10; i <= r + 13; i++) e_stall[i] = 1'b1;
    rsp_lat = 4;
    bus.start_div = 1'b1; bus.operand_a = 9; bus.operand_b = 3; bus.dest_tag = 6;
    repeat (4) step();
    r2 = cyc;
    chk("drain_release_cycle", W'(r2 - r), 14);
    plan_op(r2, 4, 1'b0, 1'b1, 9, 3, 6);
    repeat (7) step();
    bus.start_div = 1'b0;
    chk("flush_div_result_lit", bus.result, 3);
    chk("flush_div_delay",      W'(last_valid - r2), 6);
    step();

    // asynchronous reset mid-WAIT, stale ready afterwards
    r = cyc; rsp_lat = 20;
    plan_op(r, 20, 1'b0, 1'b0, 2, 2, 1);
    bus.start_mult = 1'b1; bus.operand_a = 2; bus.operand_b = 2; bus.dest_tag = 1;
    repeat (8) step();
    clear_from(cyc);
    bus.start_mult = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_result",       bus.result, 0);
    chk("async_rst_tag",          W'(bus.result_tag), 0);
    chk("async_rst_stall",        W'(bus.stall), 0);
    chk("async_rst_md_operand_a", bus.md_operand_a, 0);
    chk("async_rst_result_valid", W'(bus.result_valid), 0);
    step(); step();
    reset = 1'b1;
    repeat (14) step();
    run_op(1'b1, 1'b0, 12, 12, 2, 5, r);
    chk("post_rst_result_lit", bus.result, 144);
    step();

    // both starts together: multiply only
    run_op(1'b1, 1'b1, 5, 4, 7, 3, r);
    chk("both_start_result_lit", bus.result, 20);
    step();

    // fastest answer: ready in the first WAIT cycle
    run_op(1'b0, 1'b1, 100, 7, 31, 1, r);
    chk("fast_div_delay", W'(last_valid - r), 3);
    step();

    // ready in the last WAIT cycle beats the timeout
    run_op(1'b1, 1'b0, 1000, 1000, 8, 40, r);
    chk("late_ready_result_lit", bus.result, 1000000);
    chk("late_ready_exc_lit",    W'(bus.result_exception), 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
